// File: rtl/midi_tx_fifo.sv
// Buffered MIDI 8N1 transmitter: a byte FIFO feeds a start/data/stop serialiser,
// with optional running-status suppression of repeated channel status bytes.
module midi_tx_fifo #(
  parameter int CLK_FREQ       = 25000000,
  parameter int BAUD           = 31250,
  parameter int BIT_CLKS       = CLK_FREQ / BAUD,
  parameter int DEPTH          = 16,
  parameter int RUNNING_STATUS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     midi_send_byte,
  input  logic [7:0]               midi_out_data,
  output logic                     midi_out_ready,
  output logic                     midi_txd,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BIT_CLKS);
  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam bit RS_EN = (RUNNING_STATUS != 0);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    last_status_q, last_status_d;
  logic          last_valid_q, last_valid_d;

  logic [7:0] mem [DEPTH];
  logic [7:0] head;
  logic       accept;
  logic       pop;
  logic       load;
  logic       bit_end;
  logic       fifo_nonempty;
  logic       head_is_chan;
  logic       head_is_common;
  logic       head_sendable;

  assign accept         = midi_send_byte & ready_q;
  assign head           = mem[rd_ptr_q];
  assign fifo_nonempty  = (count_q != '0);
  assign bit_end        = (bit_cnt_q == BIT_LAST);
  assign head_is_chan   = (head >= 8'h80) && (head <= 8'hEF);
  assign head_is_common = (head >= 8'hF0) && (head <= 8'hF7);
  // A channel status byte equal to the one last sent is redundant on the wire.
  assign head_sendable  = !(RS_EN && head_is_chan && last_valid_q && (head == last_status_q));

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= midi_out_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    txd_d         = txd_q;
    busy_d        = busy_q;
    last_status_d = last_status_q;
    last_valid_d  = last_valid_q;
    pop           = 1'b0;
    load          = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (fifo_nonempty) begin
          pop  = 1'b1;
          load = head_sendable;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          bit_idx_d = 3'd0;
          txd_d     = shift_q[0];
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          // A dropped head is left for IDLE so it costs exactly one idle cycle.
          if (fifo_nonempty && head_sendable) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            txd_d   = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (load) begin
      state_d   = START;
      bit_cnt_d = '0;
      bit_idx_d = 3'd0;
      shift_d   = head;
      txd_d     = 1'b0;
      busy_d    = 1'b1;
      if (head_is_chan) begin
        last_status_d = head;
        last_valid_d  = 1'b1;
      end else if (head_is_common) begin
        last_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(accept);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(accept) - CW'(pop);
    ready_d    = (count_d != FULL_CNT);
    overflow_d = overflow_q | (midi_send_byte & ~ready_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      txd_q         <= 1'b1;
      busy_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ready_q       <= 1'b1;
      overflow_q    <= 1'b0;
      last_status_q <= 8'h00;
      last_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      txd_q         <= txd_d;
      busy_q        <= busy_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ready_q       <= ready_d;
      overflow_q    <= overflow_d;
      last_status_q <= last_status_d;
      last_valid_q  <= last_valid_d;
    end
  end

  assign midi_out_ready = ready_q;
  assign midi_txd       = txd_q;
  assign tx_busy        = busy_q;
  assign fifo_count     = count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_midi_tx_fifo.sv
// Bench for midi_tx_fifo: frame-level reference model checked every cycle,
// line decoders for byte-order checks, directed scenarios then random traffic.
module tb_midi_tx_fifo;
  localparam int B     = 8;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * B;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       midi_send_byte = 1'b0;
  logic [7:0] midi_out_data = 8'h00;
  logic       midi_out_ready, midi_txd, tx_busy, overflow;
  logic [4:0] fifo_count;
  logic       ready0, txd0, busy0, ovf0;
  logic [4:0] count0;

  midi_tx_fifo #(.BIT_CLKS(B), .DEPTH(DEPTH), .RUNNING_STATUS(1)) dut (
    .clk(clk), .reset(reset), .midi_send_byte(midi_send_byte), .midi_out_data(midi_out_data),
    .midi_out_ready(midi_out_ready), .midi_txd(midi_txd), .tx_busy(tx_busy),
    .fifo_count(fifo_count), .overflow(overflow));

  midi_tx_fifo #(.BIT_CLKS(B), .DEPTH(DEPTH), .RUNNING_STATUS(0)) dut0 (
    .clk(clk), .reset(reset), .midi_send_byte(midi_send_byte), .midi_out_data(midi_out_data),
    .midi_out_ready(ready0), .midi_txd(txd0), .tx_busy(busy0),
    .fifo_count(count0), .overflow(ovf0));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference model: a queue of bytes plus the position inside the frame on the wire.
  logic [7:0] mq[$];
  int         m_pos = -1;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_last = 8'h00;
  bit         m_last_v = 0;
  bit         m_ovf = 0;
  bit         m_acc;
  logic [7:0] m_hd;

  function automatic bit m_sendable(input logic [7:0] b);
    return !(b >= 8'h80 && b <= 8'hEF && m_last_v && b == m_last);
  endfunction

  function automatic void m_start(input logic [7:0] b);
    m_byte = b;
    m_pos  = 0;
    if (b >= 8'h80 && b <= 8'hEF) begin
      m_last   = b;
      m_last_v = 1;
    end else if (b >= 8'hF0 && b <= 8'hF7) begin
      m_last_v = 0;
    end
  endfunction

  function automatic logic m_txd_exp();
    if (m_pos < 0) return 1'b1;
    if (m_pos < B) return 1'b0;
    if (m_pos < 9 * B) return m_byte[(m_pos - B) / B];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_pos    = -1;
      m_last_v = 0;
      m_ovf    = 0;
    end else begin
      m_acc = midi_send_byte && (mq.size() < DEPTH);
      if (midi_send_byte && !m_acc) m_ovf = 1;
      if (m_pos < 0) begin
        if (mq.size() > 0) begin
          m_hd = mq.pop_front();
          if (m_sendable(m_hd)) m_start(m_hd);
        end
      end else if (m_pos == FRAME - 1) begin
        if (mq.size() > 0 && m_sendable(mq[0])) begin
          m_hd = mq.pop_front();
          m_start(m_hd);
        end else begin
          m_pos = -1;
        end
      end else begin
        m_pos++;
      end
      if (m_acc) mq.push_back(midi_out_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_txd",   int'(midi_txd),       int'(m_txd_exp()));
      chk("cyc_busy",  int'(tx_busy),        (m_pos >= 0) ? 1 : 0);
      chk("cyc_count", int'(fifo_count),     mq.size());
      chk("cyc_ready", int'(midi_out_ready), (mq.size() != DEPTH) ? 1 : 0);
      chk("cyc_ovf",   int'(overflow),       int'(m_ovf));
    end
  end

  // Line decoders: recover bytes from each serial output by mid-bit sampling.
  int         dec_pos [2] = '{-1, -1};
  logic [7:0] dec_sh [2];
  logic [7:0] rxq0[$];
  logic [7:0] rxq1[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        dec_pos[k] = -1;
      end else if (dec_pos[k] < 0) begin
        if (((k == 0) ? midi_txd : txd0) == 1'b0) dec_pos[k] = 1;
      end else begin
        if ((dec_pos[k] % B) == B / 2 && dec_pos[k] >= B && dec_pos[k] < 9 * B)
          dec_sh[k][dec_pos[k] / B - 1] = (k == 0) ? midi_txd : txd0;
        if (dec_pos[k] == 9 * B + B / 2) begin
          $display("line%0d frame byte %02h", k, dec_sh[k]);
          if (k == 0) rxq0.push_back(dec_sh[k]);
          else rxq1.push_back(dec_sh[k]);
        end
        dec_pos[k] = (dec_pos[k] == FRAME - 1) ? -1 : dec_pos[k] + 1;
      end
    end
  end

  logic [7:0] stim_q[$];
  int busy_cyc, rises, peak;

  task automatic run_stim(input string name, input int max_cyc);
    bit prev_busy;
    bit done;
    done = 0;
    busy_cyc = 0;
    rises = 0;
    peak = 0;
    prev_busy = tx_busy;
    for (int c = 0; c < max_cyc && !done; c++) begin
      if (stim_q.size() > 0) begin
        midi_send_byte = 1'b1;
        midi_out_data  = stim_q.pop_front();
      end else begin
        midi_send_byte = 1'b0;
      end
      step();
      if (tx_busy) busy_cyc++;
      if (tx_busy && !prev_busy) rises++;
      prev_busy = tx_busy;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (!midi_send_byte && !tx_busy && fifo_count == 0 && !busy0 && count0 == 0) done = 1;
    end
    midi_send_byte = 1'b0;
    chk({name, "_done"}, int'(done), 1);
    step();
  endtask

  task automatic cmp_rx(input string name, input int which);
    chk({name, "_len"}, (which == 0) ? rxq0.size() : rxq1.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (which == 0 && i < rxq0.size()) chk($sformatf("%s_b%0d", name, i), int'(rxq0[i]), int'(exp_q[i]));
      if (which == 1 && i < rxq1.size()) chk($sformatf("%s_b%0d", name, i), int'(rxq1[i]), int'(exp_q[i]));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic write1(input logic [7:0] b);
    midi_send_byte = 1'b1;
    midi_out_data  = b;
    step();
    midi_send_byte = 1'b0;
  endtask

  task automatic wait_pos(input string name, input int pos);
    int n;
    n = 0;
    while (m_pos != pos && n < 400) begin
      step();
      n++;
    end
    chk({name, "_reached"}, m_pos, pos);
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 7))
      0, 1:    return 8'($urandom_range(0, 127));
      2, 3:    return 8'h90;
      4:       return 8'hB0;
      5:       return ($urandom_range(0, 1) != 0) ? 8'hF0 : 8'hF7;
      6:       return ($urandom_range(0, 1) != 0) ? 8'hF8 : 8'hFE;
      default: return 8'h91;
    endcase
  endfunction

  logic line_s [90];
  logic busy_s [90];
  int   bits_exp [8] = '{0, 0, 0, 0, 1, 0, 0, 1};
  int   bsum;
  int   rate;

  initial begin
    step();
    step();
    chk_en = 1;
    chk("rst_txd", int'(midi_txd), 1);
    chk("rst_ready", int'(midi_out_ready), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_ovf", int'(overflow), 0);
    reset = 1'b0;
    step();

    // Single byte from idle
    midi_send_byte = 1'b1;
    midi_out_data  = 8'h90;
    step();
    midi_send_byte = 1'b0;
    chk("single_count_after_write", int'(fifo_count), 1);
    chk("single_txd_at_accept", int'(midi_txd), 1);
    step();
    for (int i = 0; i < 90; i++) begin
      line_s[i] = midi_txd;
      busy_s[i] = tx_busy;
      if (i == 0) chk("single_count_popped", int'(fifo_count), 0);
      step();
    end
    chk("single_start", int'(line_s[0]), 0);
    chk("single_start_end", int'(line_s[B - 1]), 0);
    for (int n = 0; n < 8; n++) chk($sformatf("single_bit%0d", n), int'(line_s[(1 + n) * B + B / 2]), bits_exp[n]);
    chk("single_stop", int'(line_s[9 * B + B / 2]), 1);
    chk("single_after", int'(line_s[FRAME]), 1);
    bsum = 0;
    for (int i = 0; i < 90; i++) bsum += int'(busy_s[i]);
    chk("single_busy_cycles", bsum, 80);

    // Back-to-back frames with no gap
    rxq0.delete();
    rxq1.delete();
    stim_q = '{8'h3C, 8'h64, 8'hF8};
    run_stim("b2b", 600);
    chk("b2b_busy_cycles", busy_cyc, 240);
    chk("b2b_busy_rises", rises, 1);
    chk("b2b_peak", peak, 2);
    exp_q = '{8'h3C, 8'h64, 8'hF8};
    cmp_rx("b2b_rx", 0);

    // Running status with and without compression
    do_reset();
    rxq0.delete();
    rxq1.delete();
    stim_q = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C, 8'h00, 8'hF8, 8'h90, 8'h40};
    run_stim("rs", 2000);
    exp_q = '{8'h90, 8'h3C, 8'h64, 8'h3C, 8'h00, 8'hF8, 8'h40};
    cmp_rx("rs_on", 0);
    exp_q = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C, 8'h00, 8'hF8, 8'h90, 8'h40};
    cmp_rx("rs_off", 1);
    rxq0.delete();
    rxq1.delete();
    stim_q = '{8'hF0, 8'h90};
    run_stim("rs_sysex", 600);
    exp_q = '{8'hF0, 8'h90};
    cmp_rx("rs_sysex", 0);

    // Fill to full during a frame, then one more write
    rxq0.delete();
    rxq1.delete();
    write1(8'h55);
    step();
    step();
    for (int i = 0; i < 17; i++) begin
      midi_send_byte = 1'b1;
      midi_out_data  = 8'(8'h10 + i);
      step();
      if (i == 14) chk("full_ready_before", int'(midi_out_ready), 1);
      if (i == 15) begin
        chk("full_ready_drop", int'(midi_out_ready), 0);
        chk("full_count", int'(fifo_count), 16);
        chk("full_ovf_clear", int'(overflow), 0);
      end
    end
    midi_send_byte = 1'b0;
    chk("full_ovf_set", int'(overflow), 1);
    chk("full_count_kept", int'(fifo_count), 16);
    run_stim("full", 3000);
    exp_q = '{8'h55};
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h10 + i));
    cmp_rx("full_rx", 0);

    // Write landing on the last STOP cycle while the FIFO is non-empty
    rxq0.delete();
    rxq1.delete();
    write1(8'h21);
    write1(8'h22);
    write1(8'h23);
    write1(8'h24);
    wait_pos("simul", FRAME - 1);
    chk("simul_count_before", int'(fifo_count), 3);
    write1(8'h25);
    chk("simul_count_after", int'(fifo_count), 3);
    chk("simul_restart", int'(midi_txd), 0);
    run_stim("simul", 2000);
    exp_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    cmp_rx("simul_rx", 0);

    // Reset during data bit 3 with five bytes queued
    write1(8'h40);
    for (int i = 1; i <= 5; i++) write1(8'(i));
    wait_pos("mid", (1 + 3) * B + 2);
    chk("mid_count_queued", int'(fifo_count), 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_txd", int'(midi_txd), 1);
    chk("mid_count", int'(fifo_count), 0);
    chk("mid_busy", int'(tx_busy), 0);
    chk("mid_ovf", int'(overflow), 0);
    chk("mid_ready", int'(midi_out_ready), 1);
    rxq0.delete();
    rxq1.delete();
    stim_q = '{8'h90};
    run_stim("mid_after", 600);
    exp_q = '{8'h90};
    cmp_rx("mid_rx", 0);

    // Random traffic in alternating dense and sparse bursts
    for (int c = 0; c < 3000; c++) begin
      rate = (((c / 200) % 2) == 0) ? 70 : 6;
      reset = ($urandom_range(0, 1499) == 0) ? 1'b1 : 1'b0;
      midi_send_byte = ($urandom_range(0, 99) < rate) ? 1'b1 : 1'b0;
      midi_out_data  = rand_byte();
      step();
    end
    reset = 1'b0;
    midi_send_byte = 1'b0;
    stim_q.delete();
    run_stim("drain", 4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
